// File: rtl/vga_pkg.sv
// Shared timing defaults and coordinate type for the VGA timing generator.
package vga_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    // 640x480 @72 Hz on a 31.5 MHz pixel clock
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 24;
    localparam int H_SYNC_DEF    = 40;
    localparam int H_BP_DEF      = 128;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 9;
    localparam int V_SYNC_DEF    = 3;
    localparam int V_BP_DEF      = 28;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync polarity: value driven while the pulse is active
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift register used to delay sync/blanking to match pipelined colour logic.
module vga_delay_line #(
    parameter int                WIDTH   = 1,
    parameter int                DEPTH   = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    // Shift the input one stage per clock; every stage resets to the inactive value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= {DEPTH{RST_VAL}};
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA display timing generator: pixel coordinates, hsync/vsync, video_on, frame_tick.
// Optional feature macro VGA_SYNC_DELAY_EN: delays hsync/vsync/video_on by SYNC_DELAY
// cycles (coordinates and frame_tick stay undelayed).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter bit V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int SYNC_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] pixel_row,
    output logic [COORD_W-1:0] pixel_column,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_tick
);

    localparam int     H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be within 1..8");
    end

    coord_t r_h_cnt, r_v_cnt;
    coord_t w_h_nxt, w_v_nxt;
    logic   r_video_on, r_hsync, r_vsync, r_frame_tick;

    // Next-state counters; the flags below decode these so they line up with the coordinates
    always_comb begin
        w_h_nxt = r_h_cnt + coord_t'(1);
        w_v_nxt = r_v_cnt;
        if (r_h_cnt == H_LAST) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + coord_t'(1);
        end
    end

    // Counters and registered timing flags; reset parks at the last pixel so the first edge yields (0,0)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt      <= H_LAST;
            r_v_cnt      <= V_LAST;
            r_video_on   <= 1'b0;
            r_hsync      <= ~H_SYNC_POL;
            r_vsync      <= ~V_SYNC_POL;
            r_frame_tick <= 1'b0;
        end else begin
            r_h_cnt      <= w_h_nxt;
            r_v_cnt      <= w_v_nxt;
            r_video_on   <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
            r_hsync      <= ((w_h_nxt >= HS_START) && (w_h_nxt <= HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
            r_vsync      <= ((w_v_nxt >= VS_START) && (w_v_nxt <= VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
            r_frame_tick <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    assign pixel_column = r_h_cnt;
    assign pixel_row    = r_v_cnt;
    assign frame_tick   = r_frame_tick;

`ifdef VGA_SYNC_DELAY_EN
    logic [2:0] w_sync_dly;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL ({1'b0, ~H_SYNC_POL, ~V_SYNC_POL})
    ) u_sync_dly (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     ({r_video_on, r_hsync, r_vsync}),
        .o_q     (w_sync_dly)
    );

    assign {video_on, hsync, vsync} = w_sync_dly;
`else
    assign video_on = r_video_on;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
`endif

endmodule
